// File: rtl/matmul_tile_sequencer.sv
// Breaks one large matmul command into row-major per-tile commands for the
// systolic core, limits outstanding tiles, and returns one completion response.
module matmul_tile_sequencer #(
  parameter int TILE         = 8,
  parameter int ELEM_BYTES   = 2,
  parameter int ADDR_W       = 64,
  parameter int DIM_W        = 20,
  parameter int TCNT_W       = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clock,
  input  logic              reset,
  // top-level command
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_act_addr,
  input  logic [ADDR_W-1:0] i_cmd_wgt_addr,
  input  logic [ADDR_W-1:0] i_cmd_out_addr,
  input  logic [TCNT_W-1:0] i_cmd_m_tiles,
  input  logic [TCNT_W-1:0] i_cmd_n_tiles,
  input  logic [DIM_W-1:0]  i_cmd_inner_dimension,
  // top-level completion
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_tile_count,
  // per-tile command to the core
  output logic              o_tile_cmd_valid,
  input  logic              i_tile_cmd_ready,
  output logic [ADDR_W-1:0] o_tile_cmd_act_addr,
  output logic [ADDR_W-1:0] o_tile_cmd_wgt_addr,
  output logic [ADDR_W-1:0] o_tile_cmd_out_addr,
  output logic [DIM_W-1:0]  o_tile_cmd_inner_dim,
  // per-tile completion from the core
  input  logic              i_tile_resp_valid,
  output logic              o_tile_resp_ready,
  output logic              o_busy
);

  localparam int LOG_TILE = $clog2(TILE);
  localparam int LOG_EB   = $clog2(ELEM_BYTES);
  localparam int AS_SHIFT = LOG_TILE + LOG_EB;
  localparam int IF_W     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [ADDR_W-1:0] OUT_STRIDE = ADDR_W'(1) << (2 * LOG_TILE + LOG_EB);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_act;
  logic [ADDR_W-1:0]   r_wgt;
  logic [ADDR_W-1:0]   r_out;
  logic [ADDR_W-1:0]   r_wgt_base;
  logic [ADDR_W-1:0]   r_stride;
  logic [DIM_W-1:0]    r_k;
  logic [TCNT_W-1:0]   r_m;
  logic [TCNT_W-1:0]   r_n;
  logic [TCNT_W-1:0]   r_i;
  logic [TCNT_W-1:0]   r_j;
  logic [IF_W-1:0]     r_inflight;
  logic [31:0]         r_issued;
  logic [31:0]         r_done;

  logic w_cmd_fire;
  logic w_tile_fire;
  logic w_tresp_fire;
  logic w_resp_fire;
  logic w_empty_cmd;
  logic w_last_col;
  logic w_last_tile;
  logic [31:0] w_done_next;

  assign w_cmd_fire   = i_cmd_valid & o_cmd_ready;
  assign w_tile_fire  = o_tile_cmd_valid & i_tile_cmd_ready;
  assign w_tresp_fire = i_tile_resp_valid & o_tile_resp_ready;
  assign w_resp_fire  = o_resp_valid & i_resp_ready;
  assign w_empty_cmd  = (i_cmd_m_tiles == '0) | (i_cmd_n_tiles == '0) |
                        (i_cmd_inner_dimension == '0);
  assign w_last_col   = (r_j == r_n - TCNT_W'(1));
  assign w_last_tile  = w_last_col & (r_i == r_m - TCNT_W'(1));
  // Looking at the done count including this cycle's response lets RESP follow
  // the final tile response by exactly one cycle.
  assign w_done_next  = r_done + {31'd0, w_tresp_fire};

  assign o_tile_cmd_act_addr  = r_act;
  assign o_tile_cmd_wgt_addr  = r_wgt;
  assign o_tile_cmd_out_addr  = r_out;
  assign o_tile_cmd_inner_dim = r_k;
  assign o_resp_tile_count    = r_done;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and handshake outputs; every output gets a default first.
  always_comb begin
    // NOTE: assigning defaults at the top keeps every path covered so no latch is inferred.
    w_state_next      = r_state;
    o_cmd_ready       = 1'b0;
    o_busy            = 1'b1;
    o_resp_valid      = 1'b0;
    o_tile_cmd_valid  = 1'b0;
    o_tile_resp_ready = (r_inflight != '0);
    unique case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_cmd_valid) w_state_next = w_empty_cmd ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        o_tile_cmd_valid = (r_inflight < IF_W'(MAX_INFLIGHT));
        if (o_tile_cmd_valid && i_tile_cmd_ready && w_last_tile) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_done_next == r_issued) w_state_next = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Command latch, incremental tile addressing, inflight and completion counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_act      <= '0;
      r_wgt      <= '0;
      r_out      <= '0;
      r_wgt_base <= '0;
      r_stride   <= '0;
      r_k        <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_inflight <= '0;
      r_issued   <= '0;
      r_done     <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_act      <= i_cmd_act_addr;
        r_wgt      <= i_cmd_wgt_addr;
        r_out      <= i_cmd_out_addr;
        r_wgt_base <= i_cmd_wgt_addr;
        r_stride   <= ADDR_W'(i_cmd_inner_dimension) << AS_SHIFT;
        r_k        <= i_cmd_inner_dimension;
        r_m        <= i_cmd_m_tiles;
        r_n        <= i_cmd_n_tiles;
        r_i        <= '0;
        r_j        <= '0;
      end

      if (w_tile_fire) begin
        r_issued <= r_issued + 32'd1;
        r_out    <= r_out + OUT_STRIDE;
        if (w_last_col) begin
          r_j   <= '0;
          r_i   <= r_i + TCNT_W'(1);
          r_wgt <= r_wgt_base;
          r_act <= r_act + r_stride;
        end else begin
          r_j   <= r_j + TCNT_W'(1);
          r_wgt <= r_wgt + r_stride;
        end
      end

      unique case ({w_tile_fire, w_tresp_fire})
        2'b10:   r_inflight <= r_inflight + IF_W'(1);
        2'b01:   r_inflight <= r_inflight - IF_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (w_tresp_fire) r_done <= w_done_next;

      if (w_resp_fire) begin
        r_issued <= '0;
        r_done   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: a transaction-level model predicts
// every handshake and tile address each cycle; literal checks pin the model.
module tb_matmul_tile_sequencer;

  localparam int TILE = 8, EB = 2, ADDR_W = 64, DIM_W = 20, TCNT_W = 16, MAXI = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [ADDR_W-1:0] i_cmd_act_addr = '0, i_cmd_wgt_addr = '0, i_cmd_out_addr = '0;
  logic [TCNT_W-1:0] i_cmd_m_tiles = '0, i_cmd_n_tiles = '0;
  logic [DIM_W-1:0]  i_cmd_inner_dimension = '0;
  logic              o_resp_valid;
  logic              i_resp_ready = 1'b1;
  logic [31:0]       o_resp_tile_count;
  logic              o_tile_cmd_valid;
  logic              i_tile_cmd_ready = 1'b1;
  logic [ADDR_W-1:0] o_tile_cmd_act_addr, o_tile_cmd_wgt_addr, o_tile_cmd_out_addr;
  logic [DIM_W-1:0]  o_tile_cmd_inner_dim;
  logic              i_tile_resp_valid = 1'b0;
  logic              o_tile_resp_ready;
  logic              o_busy;

  matmul_tile_sequencer #(
    .TILE(TILE), .ELEM_BYTES(EB), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
    .TCNT_W(TCNT_W), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clock(clock), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_act_addr(i_cmd_act_addr), .i_cmd_wgt_addr(i_cmd_wgt_addr),
    .i_cmd_out_addr(i_cmd_out_addr), .i_cmd_m_tiles(i_cmd_m_tiles),
    .i_cmd_n_tiles(i_cmd_n_tiles), .i_cmd_inner_dimension(i_cmd_inner_dimension),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_tile_count(o_resp_tile_count),
    .o_tile_cmd_valid(o_tile_cmd_valid), .i_tile_cmd_ready(i_tile_cmd_ready),
    .o_tile_cmd_act_addr(o_tile_cmd_act_addr), .o_tile_cmd_wgt_addr(o_tile_cmd_wgt_addr),
    .o_tile_cmd_out_addr(o_tile_cmd_out_addr), .o_tile_cmd_inner_dim(o_tile_cmd_inner_dim),
    .i_tile_resp_valid(i_tile_resp_valid), .o_tile_resp_ready(o_tile_resp_ready),
    .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_active = 0, m_pending = 0;
  longint      m_total = 0, m_next = 0, m_resp = 0;
  logic [63:0] m_act = '0, m_wgt = '0, m_out = '0, m_as = '0;
  longint      m_n = 1;
  logic [DIM_W-1:0] m_k = '0;
  int          n_fire = 0;
  logic [63:0] rec_act [64], rec_wgt [64], rec_out [64];

  localparam logic [63:0] OS = 64'(TILE * TILE * EB);

  always @(negedge clock) begin
    bit     exp_valid, resp_fire;
    longint ti, tj;
    if (reset) begin
      m_active = 0; m_pending = 0; m_total = 0; m_next = 0; m_resp = 0;
    end else begin
      exp_valid = m_active && !m_pending && (m_next < m_total) && ((m_next - m_resp) < MAXI);
      check("cmd_ready", o_cmd_ready, !m_active);
      check("busy", o_busy, m_active);
      check("resp_valid", o_resp_valid, m_pending);
      check("tile_cmd_valid", o_tile_cmd_valid, exp_valid);
      check("tile_resp_ready", o_tile_resp_ready, m_next != m_resp);
      if (m_pending) check("resp_tile_count", o_resp_tile_count, 64'(m_resp));
      if (exp_valid) begin
        ti = m_next / m_n;
        tj = m_next % m_n;
        check("tile_act", o_tile_cmd_act_addr, m_act + 64'(ti) * m_as);
        check("tile_wgt", o_tile_cmd_wgt_addr, m_wgt + 64'(tj) * m_as);
        check("tile_out", o_tile_cmd_out_addr, m_out + 64'(m_next) * OS);
        check("tile_k", o_tile_cmd_inner_dim, m_k);
      end
      // advance the model with the handshakes that complete at the coming edge
      resp_fire = m_pending && i_resp_ready;
      if (i_cmd_valid && o_cmd_ready) begin
        m_active = 1;
        m_act = i_cmd_act_addr; m_wgt = i_cmd_wgt_addr; m_out = i_cmd_out_addr;
        m_k = i_cmd_inner_dimension;
        m_as = 64'(i_cmd_inner_dimension) * TILE * EB;
        m_n = (i_cmd_n_tiles == 0) ? 1 : longint'(i_cmd_n_tiles);
        m_total = (i_cmd_inner_dimension == 0) ? 0
                : longint'(i_cmd_m_tiles) * longint'(i_cmd_n_tiles);
        m_next = 0; m_resp = 0;
        m_pending = (m_total == 0);
      end else if (m_active) begin
        if (o_tile_cmd_valid && i_tile_cmd_ready) begin
          rec_act[n_fire % 64] = o_tile_cmd_act_addr;
          rec_wgt[n_fire % 64] = o_tile_cmd_wgt_addr;
          rec_out[n_fire % 64] = o_tile_cmd_out_addr;
          n_fire++;
          m_next++;
        end
        if (i_tile_resp_valid && o_tile_resp_ready) m_resp++;
        if (resp_fire) begin
          m_active = 0; m_pending = 0;
        end else if (!m_pending && m_next == m_total && m_resp == m_total) begin
          m_pending = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [63:0] w, input logic [63:0] o,
                          input int m, input int n, input int k);
    bit seen;
    seen = 0;
    tick();
    i_cmd_act_addr = a; i_cmd_wgt_addr = w; i_cmd_out_addr = o;
    i_cmd_m_tiles = TCNT_W'(m); i_cmd_n_tiles = TCNT_W'(n);
    i_cmd_inner_dimension = DIM_W'(k);
    i_cmd_valid = 1'b1;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clock);
      if (o_cmd_ready) seen = 1;
    end
    check("cmd_accept_seen", 64'(seen), 64'd1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int exp_count);
    bit seen;
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clock);
      if (o_resp_valid) seen = 1;
    end
    check({name, "_resp_seen"}, 64'(seen), 64'd1);
    check({name, "_count"}, o_resp_tile_count, 64'(exp_count));
    tick();
  endtask

  task automatic wait_fires(input string name, input int target);
    bit seen;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      if (n_fire >= target) seen = 1;
    end
    check({name, "_fires_seen"}, 64'(seen), 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int f0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_tile_valid", o_tile_cmd_valid, 0);
    check("rst_count", o_resp_tile_count, 0);
    check("rst_act", o_tile_cmd_act_addr, 0);
    check("rst_out", o_tile_cmd_out_addr, 0);

    // 1: 2x2 tiles, K=16, core always ready, immediate responses
    i_tile_resp_valid = 1'b1;
    f0 = n_fire;
    send_cmd(64'h1000, 64'h2000, 64'h3000, 2, 2, 16);
    wait_resp("t1", 4);
    check("t1_fires", 64'(n_fire - f0), 4);
    check("t1_a0", rec_act[f0 % 64], 64'h1000);
    check("t1_w0", rec_wgt[f0 % 64], 64'h2000);
    check("t1_o0", rec_out[f0 % 64], 64'h3000);
    check("t1_w1", rec_wgt[(f0 + 1) % 64], 64'h2100);
    check("t1_o1", rec_out[(f0 + 1) % 64], 64'h3080);
    check("t1_a2", rec_act[(f0 + 2) % 64], 64'h1100);
    check("t1_w2", rec_wgt[(f0 + 2) % 64], 64'h2000);
    check("t1_o2", rec_out[(f0 + 2) % 64], 64'h3100);
    check("t1_a3", rec_act[(f0 + 3) % 64], 64'h1100);
    check("t1_w3", rec_wgt[(f0 + 3) % 64], 64'h2100);
    check("t1_o3", rec_out[(f0 + 3) % 64], 64'h3180);

    // 2: degenerate commands respond one cycle after accept with count 0
    f0 = n_fire;
    send_cmd(64'h10, 64'h20, 64'h30, 0, 3, 4);
    @(negedge clock);
    check("t2m_resp_valid", o_resp_valid, 1);
    check("t2m_count", o_resp_tile_count, 0);
    tick();
    send_cmd(64'h10, 64'h20, 64'h30, 3, 3, 0);
    @(negedge clock);
    check("t2k_resp_valid", o_resp_valid, 1);
    check("t2k_count", o_resp_tile_count, 0);
    tick();
    check("t2_no_tiles", 64'(n_fire - f0), 0);

    // 3: stall the second tile for 5 cycles
    f0 = n_fire;
    send_cmd(64'h4000, 64'h5000, 64'h6000, 2, 2, 4);
    wait_fires("t3a", f0 + 1);
    i_tile_cmd_ready = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    check("t3_held_valid", o_tile_cmd_valid, 1);
    check("t3_held_act", o_tile_cmd_act_addr, 64'h4000);
    check("t3_held_wgt", o_tile_cmd_wgt_addr, 64'h5040);
    check("t3_held_out", o_tile_cmd_out_addr, 64'h6080);
    tick();
    i_tile_cmd_ready = 1'b1;
    wait_resp("t3", 4);

    // 4: silent core: exactly MAX_INFLIGHT tiles, one response releases one more
    i_tile_resp_valid = 1'b0;
    f0 = n_fire;
    send_cmd(64'h100, 64'h200, 64'h300, 2, 2, 2);
    repeat (10) tick();
    @(negedge clock);
    check("t4_two_issued", 64'(n_fire - f0), 2);
    check("t4_valid_low", o_tile_cmd_valid, 0);
    tick();
    i_cmd_valid = 1'b1;                  // ignored outside IDLE
    i_cmd_m_tiles = 16'd7;
    repeat (2) tick();
    i_cmd_valid = 1'b0;
    i_tile_resp_valid = 1'b1;
    tick();
    i_tile_resp_valid = 1'b0;
    repeat (3) tick();
    check("t4_third_issued", 64'(n_fire - f0), 3);
    i_tile_resp_valid = 1'b1;
    wait_resp("t4", 4);

    // 5: overlapping issue and response keep inflight steady
    f0 = n_fire;
    send_cmd(64'h0, 64'h8000, 64'h9000, 1, 3, 1);
    wait_resp("t5", 3);
    check("t5_fires", 64'(n_fire - f0), 3);

    // 6: reset in DRAIN with two tiles outstanding
    i_tile_resp_valid = 1'b0;
    f0 = n_fire;
    send_cmd(64'h700, 64'h800, 64'h900, 1, 2, 8);
    wait_fires("t6a", f0 + 2);
    repeat (2) tick();
    @(negedge clock);
    check("t6_drain_busy", o_busy, 1);
    check("t6_drain_rready", o_tile_resp_ready, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("t6_cmd_ready", o_cmd_ready, 1);
    check("t6_busy", o_busy, 0);
    check("t6_resp_valid", o_resp_valid, 0);
    check("t6_rready", o_tile_resp_ready, 0);
    i_tile_resp_valid = 1'b1;
    send_cmd(64'hA00, 64'hB00, 64'hC00, 1, 1, 3);
    wait_resp("t6", 1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
